req_arbiter4: RTL and testbench

Sequential arbiter sharing one downstream resource between four requesters, using the same bit-priority convention as the team's 4-bit priority encoders (bit 3 highest). It samples a 4-bit request vector, issues a registered one-hot grant plus encoded ID, and holds the grant until the owner releases it or a hold timeout forces revocation. It sits between the requesting agents and the shared datapath.

---
 rtl/req_arbiter4.sv | 131 +++++++++++++
 tb/tb_req_arbiter4.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/req_arbiter4.sv
// Four-way request arbiter: registered one-hot grant held until release or hold-limit revocation.
// Define ARB_ROUND_ROBIN_EN for rotating priority; fixed priority (bit 3 highest) otherwise.
module req_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HCNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StRecover} state_e;

  state_e              r_state, w_state_nxt;
  logic [3:0]          r_gnt, w_gnt_nxt;
  logic [1:0]          r_gnt_id, w_gnt_id_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic [HCNT_W-1:0]   r_hcnt, w_hcnt_nxt;
  logic [1:0]          w_win;
  logic                w_limit;
  logic                w_release;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] w_idx;
  logic       w_found;

  // Search downward from the pointer, wrapping modulo 4.
  always_comb begin
    w_win   = r_ptr;
    w_idx   = 2'd0;
    w_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr - 2'(k);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    if (req[3])      w_win = 2'd3;
    else if (req[2]) w_win = 2'd2;
    else if (req[1]) w_win = 2'd1;
    else             w_win = 2'd0;
  end
`endif

  assign w_limit   = (r_hcnt == HCNT_W'(MAX_HOLD - 1));
  assign w_release = done | ~req[r_gnt_id];

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_hcnt_nxt    = r_hcnt;
`ifdef ARB_ROUND_ROBIN_EN
    w_ptr_nxt     = r_ptr;
`endif
    unique case (r_state)
      StIdle: begin
        if (|req) begin
          w_gnt_nxt    = 4'b0001 << w_win;
          w_gnt_id_nxt = w_win;
          w_hcnt_nxt   = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = StGrant;
`ifdef ARB_ROUND_ROBIN_EN
          // The winner becomes lowest priority; a later timeout leaves the same pointer.
          w_ptr_nxt    = w_win - 2'd1;
`endif
        end
      end
      StGrant: begin
        w_hcnt_nxt = r_hcnt + 1'b1;
        // Release wins over the hold limit, so no timeout pulse on a collision.
        if (w_release || w_limit) begin
          w_gnt_nxt     = 4'b0000;
          w_busy_nxt    = 1'b0;
          w_timeout_nxt = ~w_release;
          w_state_nxt   = StRecover;
        end
      end
      StRecover: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_gnt     <= 4'b0000;
      r_gnt_id  <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_hcnt    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr     <= 2'd3;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_hcnt    <= w_hcnt_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr     <= w_ptr_nxt;
`endif
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_req_arbiter4.sv
// Scoreboard bench for req_arbiter4 (MAX_HOLD=4); expectations are queued per clock edge.
module tb_req_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event ev_async;

  req_arbiter4 #(.MAX_HOLD(4), .HCNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic compare(input exp_t e);
    checks++;
    if (gnt !== e.g || gnt_id !== e.id || busy !== e.b || timeout !== e.t) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b timeout=%b, want gnt=%b id=%0d busy=%b timeout=%b",
               e.name, gnt, gnt_id, busy, timeout, e.g, e.id, e.b, e.t);
    end
  endtask

  // Monitor: one expectation per active edge, sampled 2 time units after it.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) compare(q.pop_front());
  end

  // Monitor path for checks that must not wait for a clock edge.
  always @(ev_async) begin
    if (q.size() > 0) compare(q.pop_front());
  end

  // Apply inputs for the next edge and queue the outputs expected after it.
  task automatic cyc(input string name, input logic [3:0] r, input logic d,
                     input logic [3:0] eg, input logic [1:0] eid, input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    e.name = name; e.g = eg; e.id = eid; e.b = eb; e.t = et;
    q.push_back(e);
  endtask

  task automatic push_now(input string name, input logic [3:0] eg, input logic [1:0] eid,
                          input logic eb, input logic et);
    exp_t e;
    e.name = name; e.g = eg; e.id = eid; e.b = eb; e.t = et;
    q.push_back(e);
  endtask

  logic [1:0] rr_ids [5];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_ids = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
    rr_ids = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    #1;
    push_now("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    ->ev_async;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) cyc("idle", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Priority and done release, then low requester after the gap.
    cyc("pri_grant",   4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("pri_hold1",   4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("pri_hold2",   4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("pri_done",    4'b0101, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    cyc("pri_recover", 4'b0001, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
    cyc("pri_regrant", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc("pri_rel",     4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc("pri_gap",     4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold-limit revocation.
    cyc("to_grant",   4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc("to_hold1",   4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc("to_hold2",   4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc("to_hold3",   4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc("to_revoke",  4'b1000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b1);
    cyc("to_recover", 4'b1000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);
    cyc("to_regrant", 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc("to_withdraw",4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);
    cyc("to_gap",     4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);

    // done coincides with the limit: no timeout pulse.
    cyc("col_grant", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("col_hold1", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("col_hold2", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("col_hold3", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("col_edge",  4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    cyc("col_gap",   4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Owner withdraws while others request; next grant only after the gap.
    cyc("wd_grant",   4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("wd_change",  4'b1100, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
    cyc("wd_recover", 4'b1100, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
    cyc("wd_regrant", 4'b1100, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc("wd_rel",     4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);
    cyc("wd_gap",     4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);

    // Asynchronous reset between edges while granted.
    cyc("ar_grant", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    push_now("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    ->ev_async;
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b0;

    // All requesting; done pulsed for each owner.
    for (int i = 0; i < 5; i++) begin
      cyc("rr_grant",   4'b1111, 1'b0, 4'b0001 << rr_ids[i], rr_ids[i], 1'b1, 1'b0);
      cyc("rr_done",    4'b1111, 1'b1, 4'b0000, rr_ids[i], 1'b0, 1'b0);
      cyc("rr_recover", 4'b1111, 1'b0, 4'b0000, rr_ids[i], 1'b0, 1'b0);
    end

    @(negedge clk);
    req = 4'b0000; done = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
